// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between the instruction-fetch and data ports.
// One access at a time, registered memory handshake, one-cycle ready pulse per access.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access in flight; arbitrate sampled requests
// BUSY_I  | fetch access driven on memory side, waiting for mem_ack_i
// BUSY_D  | data access driven on memory side, waiting for mem_ack_i
// RESP    | one-cycle ready pulse to the served port, no arbitration
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int D_STREAK_MAX = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic [DATA_W-1:0] i_rdata_o,
    output logic              i_ready_o,
    output logic              i_stall_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ready_o,
    output logic              d_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam int SW = $clog2(D_STREAK_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK_MAX);
    localparam logic [TW-1:0] TMO_LOAD   = TW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [SW-1:0] streak;
    logic [TW-1:0] tmo_cnt;
    logic          grant_i;
    logic          grant_d;

    // Data port wins ties until it has starved fetch for D_STREAK_MAX grants in a row.
    assign grant_d = d_req_i & (~i_req_i | (streak != STREAK_MAX));
    assign grant_i = i_req_i & ~grant_d;

    assign i_stall_o = i_req_i & ~i_ready_o;
    assign d_stall_o = d_req_i & ~d_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= ST_IDLE;
            streak      <= '0;
            tmo_cnt     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            i_ready_o   <= 1'b0;
            i_rdata_o   <= '0;
            d_ready_o   <= 1'b0;
            d_rdata_o   <= '0;
            err_o       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    i_ready_o <= 1'b0;
                    d_ready_o <= 1'b0;
                    i_rdata_o <= '0;
                    d_rdata_o <= '0;
                    if (grant_d) begin
                        state       <= ST_BUSY_D;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= d_we_i;
                        mem_addr_o  <= d_addr_i;
                        mem_wdata_o <= d_wdata_i;
                        tmo_cnt     <= TMO_LOAD;
                        if (i_req_i) begin
                            if (streak != STREAK_MAX) streak <= streak + 1'b1;
                        end else begin
                            streak <= '0;
                        end
                    end else if (grant_i) begin
                        state       <= ST_BUSY_I;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= i_addr_i;
                        mem_wdata_o <= '0;
                        tmo_cnt     <= TMO_LOAD;
                        streak      <= '0;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    // An ack in the last allowed cycle still completes normally.
                    if (mem_ack_i || (tmo_cnt == '0)) begin
                        mem_req_o <= 1'b0;
                        state     <= ST_RESP;
                        if (state == ST_BUSY_I) begin
                            i_ready_o <= 1'b1;
                            i_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
                        end else begin
                            d_ready_o <= 1'b1;
                            d_rdata_o <= (mem_ack_i && !mem_we_o) ? mem_rdata_i : '0;
                        end
                        if (!mem_ack_i) err_o <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    i_ready_o <= 1'b0;
                    d_ready_o <= 1'b0;
                    i_rdata_o <= '0;
                    d_rdata_o <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner sequences, randomized traffic
// against a transaction-level model of arbitration order and memory contents.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int TMO  = 64;
    localparam int SMAX = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        i_req_i = 1'b0;
    logic [31:0] i_addr_i = '0;
    logic [31:0] i_rdata_o;
    logic        i_ready_o, i_stall_o;
    logic        d_req_i = 1'b0;
    logic        d_we_i = 1'b0;
    logic [31:0] d_addr_i = '0;
    logic [31:0] d_wdata_i = '0;
    logic [31:0] d_rdata_o;
    logic        d_ready_o, d_stall_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .D_STREAK_MAX(SMAX), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o),
        .i_ready_o(i_ready_o), .i_stall_o(i_stall_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o), .d_stall_o(d_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .err_o(err_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // Memory model: unwritten words read back as a pattern derived from the address.
    logic [31:0] tb_mem [logic [31:0]];
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (tb_mem.exists(a)) return tb_mem[a];
        return a ^ 32'hA5A50000;
    endfunction

    int ack_lat = 1;        // cycles from first mem_req to ack; 0 = never ack
    bit rand_lat = 1'b0;
    int force_ack_cyc = -1; // stray ack injected in this cycle

    initial begin
        int wcnt;
        int cur_lat;
        wcnt = 0;
        cur_lat = 0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_ack_i = 1'b0;
            mem_rdata_i = '0;
            if (mem_req_o) begin
                wcnt++;
                if (wcnt == 1) cur_lat = rand_lat ? int'($urandom_range(1, 4)) : ack_lat;
                if (cur_lat != 0 && wcnt == cur_lat) begin
                    mem_ack_i = 1'b1;
                    if (mem_we_o) begin
                        tb_mem[mem_addr_o] = mem_wdata_o;
                        mem_rdata_i = 32'h0BADF00D;
                    end else begin
                        mem_rdata_i = mem_rd(mem_addr_o);
                    end
                end
            end else begin
                wcnt = 0;
            end
            if (cyc == force_ack_cyc) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = 32'hDEADBEEF;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_i = 1'b0;
        i_req_i = 1'b0;
        d_req_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
    endtask

    // One single-port access; checks latching, latency, rdata and pulse clearing.
    task automatic do_access(input logic is_d, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int lat, input logic [31:0] want,
                             input logic err_pre);
        int c0, creq, crdy;
        creq = -1;
        crdy = -1;
        tick();
        ack_lat = lat;
        if (is_d) begin
            d_req_i = 1'b1; d_we_i = we; d_addr_i = addr; d_wdata_i = wdata;
        end else begin
            i_req_i = 1'b1; i_addr_i = addr;
        end
        c0 = cyc;
        for (int k = 0; k < 100; k++) begin
            #4;
            if (mem_req_o) begin
                if (creq < 0) begin
                    creq = cyc;
                    chk("err_at_grant", err_o, err_pre);
                end
                chk("mem_addr", mem_addr_o, addr);
                chk("mem_we", mem_we_o, is_d ? we : 1'b0);
                if (is_d && we) chk("mem_wdata", mem_wdata_o, wdata);
                chk("stall_busy", is_d ? d_stall_o : i_stall_o, 1'b1);
            end
            if (is_d ? d_ready_o : i_ready_o) begin
                crdy = cyc;
                chk("rdata", is_d ? d_rdata_o : i_rdata_o, want);
                chk("other_ready", is_d ? i_ready_o : d_ready_o, 1'b0);
                chk("stall_on_ready", is_d ? d_stall_o : i_stall_o, 1'b0);
                chk("mem_req_on_ready", mem_req_o, 1'b0);
                chk("err_on_ready", err_o, err_pre | (lat == 0));
                break;
            end
            tick();
            if (creq >= 0) begin
                if (is_d) begin
                    d_addr_i = ~addr; d_wdata_i = ~wdata; d_we_i = ~we;
                end else begin
                    i_addr_i = ~addr;
                end
            end
        end
        chk("req_latency", creq - c0, 1);
        chk("ready_latency", crdy - c0, (lat == 0) ? TMO + 1 : lat + 1);
        tick();
        i_req_i = 1'b0;
        d_req_i = 1'b0;
        #4;
        chk("ready_cleared", is_d ? d_ready_o : i_ready_o, 1'b0);
        chk("rdata_cleared", is_d ? d_rdata_o : i_rdata_o, '0);
    endtask

    // Both ports requesting; exp_pat bit g = 1 when grant g should go to D.
    task automatic run_pair(input int n_grants, input bit d_rep, input bit i_rep,
                            input logic [15:0] exp_pat);
        int g, done;
        bit mreq_prev, dr, ir;
        logic [15:0] pat;
        g = 0;
        done = 0;
        mreq_prev = 1'b0;
        pat = exp_pat;
        ack_lat = 1;
        tick();
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h100;
        i_req_i = 1'b1; i_addr_i = 32'h40;
        for (int k = 0; k < 400 && done < n_grants; k++) begin
            #4;
            if (i_req_i && !i_ready_o) chk("pair_i_stall", i_stall_o, 1'b1);
            if (mem_req_o && !mreq_prev) begin
                chk($sformatf("pair_grant%0d_is_d", g), mem_addr_o >= 32'h100, pat[g]);
                g++;
            end
            mreq_prev = mem_req_o;
            dr = d_ready_o;
            ir = i_ready_o;
            if (dr || ir) done++;
            tick();
            if (dr) begin
                if (d_rep) d_addr_i = d_addr_i + 32'd4;
                else d_req_i = 1'b0;
            end
            if (ir) begin
                if (i_rep) i_addr_i = i_addr_i + 32'd4;
                else i_req_i = 1'b0;
            end
        end
        chk("pair_completed", done, n_grants);
        i_req_i = 1'b0;
        d_req_i = 1'b0;
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h040, 32'h0,        1, 32'hA5A50040};
        vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,        2, 32'hA5A50100};
        vecs[2] = '{1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 5, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h200, 32'h0,        3, 32'hCAFEF00D};
        vecs[4] = '{1'b0, 1'b0, 32'h200, 32'h0,        1, 32'hCAFEF00D};
        vecs[5] = '{1'b0, 1'b0, 32'h044, 32'h0,        4, 32'hA5A50044};

        // Reset state
        tick();
        tick();
        #4;
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_mem_we", mem_we_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, '0);
        chk("rst_i_ready", i_ready_o, 1'b0);
        chk("rst_d_ready", d_ready_o, 1'b0);
        chk("rst_i_rdata", i_rdata_o, '0);
        chk("rst_d_rdata", d_rdata_o, '0);
        chk("rst_err", err_o, 1'b0);
        tick();
        rst_i = 1'b1;

        foreach (vecs[v])
            do_access(vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                      vecs[v].lat, vecs[v].rdata, 1'b0);

        // Simultaneous requests: D first, then I
        do_reset();
        run_pair(2, 1'b0, 1'b0, 16'h0001);
        // Continuous requests on both ports: four D grants, then I, then the pattern repeats
        do_reset();
        run_pair(10, 1'b1, 1'b1, 16'h01EF);

        // Timeout with no ack, sticky error, cleared only by reset
        do_reset();
        do_access(1'b1, 1'b0, 32'h300, 32'h0, 0, 32'h0, 1'b0);
        do_access(1'b0, 1'b0, 32'h040, 32'h0, 1, 32'hA5A50040, 1'b1);
        chk("err_sticky", err_o, 1'b1);
        do_reset();
        #4;
        chk("err_cleared_by_reset", err_o, 1'b0);

        // Reset during BUSY_D, then a stray ack in IDLE
        tick();
        ack_lat = 0;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h100;
        tick();
        tick();
        #4;
        chk("busy_before_rst", mem_req_o, 1'b1);
        tick();
        rst_i = 1'b0;
        force_ack_cyc = cyc + 1;
        tick();
        rst_i = 1'b1;
        d_req_i = 1'b0;
        #4;
        chk("rst_abort_mem_req", mem_req_o, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            #4;
            chk("late_ack_no_d_ready", d_ready_o, 1'b0);
            chk("late_ack_no_i_ready", i_ready_o, 1'b0);
            chk("late_ack_mem_req", mem_req_o, 1'b0);
        end
        force_ack_cyc = -1;

        // Randomized traffic against the transaction-level model
        do_reset();
        rand_lat = 1'b1;
        begin
            bit ip, dp, dwe_p, pi_rdy, pd_rdy, prev_ack, mreq_prev, out_v, out_d, exp_d;
            logic [31:0] ia_p, da_p, dwd_p, out_rdata;
            int ms, i_wait, d_wait;
            pi_rdy = 0; pd_rdy = 0; prev_ack = 0; mreq_prev = 0; out_v = 0; out_d = 0;
            out_rdata = '0; ms = 0; i_wait = 0; d_wait = 0;
            for (int k = 0; k < 3000; k++) begin
                tick();
                ip = i_req_i; dp = d_req_i;
                ia_p = i_addr_i; da_p = d_addr_i; dwe_p = d_we_i; dwd_p = d_wdata_i;
                if (pi_rdy) i_req_i = 1'b0;
                if (pd_rdy) d_req_i = 1'b0;
                if (!i_req_i && ($urandom % 4 == 0)) begin
                    i_req_i = 1'b1;
                    i_addr_i = {$urandom_range(0, 7), 2'b00};
                end
                if (!d_req_i && ($urandom % 3 == 0)) begin
                    d_req_i = 1'b1;
                    d_we_i = 1'($urandom % 2);
                    d_addr_i = {$urandom_range(0, 7), 2'b00};
                    d_wdata_i = $urandom;
                end
                #4;
                if (mem_req_o && !mreq_prev) begin
                    chk("rnd_grant_has_req", ip | dp, 1'b1);
                    chk("rnd_single_outstanding", out_v, 1'b0);
                    exp_d = (ip && dp) ? (ms != SMAX) : dp;
                    if (exp_d) ms = ip ? ((ms < SMAX) ? ms + 1 : SMAX) : 0;
                    else ms = 0;
                    chk("rnd_mem_addr", mem_addr_o, exp_d ? da_p : ia_p);
                    chk("rnd_mem_we", mem_we_o, exp_d ? dwe_p : 1'b0);
                    if (exp_d && dwe_p) chk("rnd_mem_wdata", mem_wdata_o, dwd_p);
                    out_v = 1'b1;
                    out_d = exp_d;
                    out_rdata = (exp_d && dwe_p) ? 32'h0 : mem_rd(exp_d ? da_p : ia_p);
                end
                if (i_ready_o || d_ready_o) begin
                    chk("rnd_ready_expected", out_v, 1'b1);
                    chk("rnd_ready_port", d_ready_o, out_d);
                    chk("rnd_ready_exclusive", i_ready_o & d_ready_o, 1'b0);
                    chk("rnd_rdata", d_ready_o ? d_rdata_o : i_rdata_o, out_rdata);
                    chk("rnd_ready_after_ack", prev_ack, 1'b1);
                    out_v = 1'b0;
                end
                chk("rnd_i_stall", i_stall_o, i_req_i & ~i_ready_o);
                chk("rnd_d_stall", d_stall_o, d_req_i & ~d_ready_o);
                i_wait = (i_req_i && !i_ready_o) ? i_wait + 1 : 0;
                d_wait = (d_req_i && !d_ready_o) ? d_wait + 1 : 0;
                if (i_wait > 200 || d_wait > 200) begin
                    chk("rnd_starvation_bound", 1'b1, 1'b0);
                    i_wait = 0;
                    d_wait = 0;
                end
                pi_rdy = i_ready_o; pd_rdy = d_ready_o;
                prev_ack = mem_ack_i; mreq_prev = mem_req_o;
            end
            chk("rnd_err_clear", err_o, 1'b0);
        end
        i_req_i = 1'b0;
        d_req_i = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
